// File: rtl/video_dma_multibuf_control_slave.sv
// video_dma_multibuf_control_slave
// Avalon-MM control slave for the pixel DMA. It holds a ring of NUM_BUFFERS
// frame-buffer base addresses. Software requests an advance by writing FRONT,
// and the advance takes effect only on the DMA's frame-boundary strobe.
// The block also keeps a frame counter, a sticky overrun flag and a
// swap-complete interrupt.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   address/byteenable/read/
//   write/writedata/readdata    Avalon-MM slave, 8 word registers, 1-cycle read
//   swap_addresses_enable       frame-boundary strobe from the DMA master
//   current_start_address       base of the buffer currently being scanned
//   next_start_address          base of the buffer the next advance selects
//   dma_enabled                 DMA run enable
//   irq                         level interrupt, set on swap when enabled
//   swap_done                   one-cycle pulse the cycle after a commit
module video_dma_multibuf_control_slave #(
  parameter int unsigned NUM_BUFFERS = 3,
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        swap_addresses_enable,
  output logic [31:0] readdata,
  output logic [31:0] current_start_address,
  output logic [31:0] next_start_address,
  output logic        dma_enabled,
  output logic        irq,
  output logic        swap_done
);

  localparam int unsigned IDX_W = $clog2(NUM_BUFFERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFFERS - 1);

  logic [31:0]      addr_tbl [NUM_BUFFERS];
  logic [IDX_W-1:0] fidx;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] slot_sel;
  logic             pending;
  logic             overrun;
  logic             irq_en;
  logic [31:0]      frame_count;

  logic             commit;
  logic             front_wr;
  logic             status_wr;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_widx;
  logic [31:0]      tbl_wdata;
  logic [31:0]      rd_mux;

  // Explicit wrap because NUM_BUFFERS need not be a power of two.
  assign next_idx  = (fidx == LAST_IDX) ? '0 : fidx + IDX_W'(1);
  assign commit    = pending & swap_addresses_enable;
  assign front_wr  = write && (address == 3'd0);
  assign status_wr = write && (address == 3'd3) && byteenable[0];

  assign current_start_address = addr_tbl[fidx];
  assign next_start_address    = addr_tbl[next_idx];

  // BACK and SLOT_ADDR share one write port. Both use the pre-commit index,
  // so a coincident commit never redirects the write.
  always_comb begin
    tbl_we    = write && ((address == 3'd1) || (address == 3'd5));
    tbl_widx  = (address == 3'd1) ? next_idx : slot_sel;
    tbl_wdata = addr_tbl[tbl_widx];
    for (int b = 0; b < 4; b++) begin
      if (byteenable[b]) tbl_wdata[8*b +: 8] = writedata[8*b +: 8];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = addr_tbl[fidx];
      3'd1: rd_mux = addr_tbl[next_idx];
      3'd2: rd_mux = {16'(HEIGHT), 16'(WIDTH)};
      3'd3: rd_mux = {8'd0, 8'(NUM_BUFFERS), 8'(fidx), 2'b00,
                      irq, irq_en, overrun, dma_enabled, 1'b1, pending};
      3'd4: rd_mux = 32'(slot_sel);
      3'd5: rd_mux = addr_tbl[slot_sel];
      3'd6: rd_mux = frame_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_BUFFERS); i++) addr_tbl[i] <= '0;
    end else if (tbl_we) begin
      addr_tbl[tbl_widx] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata    <= '0;
      fidx        <= '0;
      slot_sel    <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
      frame_count <= '0;
      dma_enabled <= 1'b1;
      swap_done   <= 1'b0;
    end else begin
      if (read) readdata <= rd_mux;
      swap_done <= commit;
      if (commit) fidx <= next_idx;

      // A FRONT write re-arms pending even when it coincides with a commit.
      if (front_wr)    pending <= 1'b1;
      else if (commit) pending <= 1'b0;

      if (front_wr && pending && !commit)     overrun <= 1'b1;
      else if (status_wr && writedata[3])     overrun <= 1'b0;

      if (status_wr) begin
        dma_enabled <= writedata[2];
        irq_en      <= writedata[4];
      end

      // Set has priority over a software clear in the same cycle.
      if (commit && irq_en)               irq <= 1'b1;
      else if (status_wr && writedata[5]) irq <= 1'b0;

      if (write && (address == 3'd6)) frame_count <= '0;
      else if (commit)                frame_count <= frame_count + 32'd1;

      if (write && (address == 3'd4) && (writedata < 32'(NUM_BUFFERS)))
        slot_sel <= writedata[IDX_W-1:0];
    end
  end

endmodule

// File: tb/tb_video_dma_multibuf_control_slave.sv
module tb_video_dma_multibuf_control_slave;

  localparam int N = 3;
  localparam int W = 640;
  localparam int H = 480;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        swap_addresses_enable;
  logic [31:0] readdata;
  logic [31:0] current_start_address;
  logic [31:0] next_start_address;
  logic        dma_enabled;
  logic        irq;
  logic        swap_done;

  video_dma_multibuf_control_slave #(.NUM_BUFFERS(N), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .swap_addresses_enable(swap_addresses_enable), .readdata(readdata),
    .current_start_address(current_start_address),
    .next_start_address(next_start_address), .dma_enabled(dma_enabled),
    .irq(irq), .swap_done(swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_tab [N];
  int          m_fidx, m_sel;
  bit          m_pend, m_ov, m_ien, m_irq, m_dma, m_sd, m_valid;
  logic [31:0] m_fc, m_rd;

  initial m_valid = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_reg(input int a);
    case (a)
      0: return m_tab[m_fidx];
      1: return m_tab[(m_fidx + 1) % N];
      2: return 32'((H << 16) + W);
      3: return 32'(int'(m_pend) + 2 + 4 * int'(m_dma) + 8 * int'(m_ov) + 16 * int'(m_ien)
                    + 32 * int'(m_irq) + 256 * m_fidx + 65536 * N);
      4: return 32'(m_sel);
      5: return m_tab[m_sel];
      6: return m_fc;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] t [N];
    int          f, s;
    bit          p, ov, ie, iq, dm, cm;
    logic [31:0] fc;
    if (reset) begin
      for (int i = 0; i < N; i++) m_tab[i] <= 32'd0;
      m_fidx <= 0; m_sel <= 0; m_pend <= 0; m_ov <= 0; m_ien <= 0; m_irq <= 0;
      m_dma <= 1; m_sd <= 0; m_fc <= 32'd0; m_rd <= 32'd0; m_valid <= 1;
    end else begin
      for (int i = 0; i < N; i++) t[i] = m_tab[i];
      f = m_fidx; s = m_sel; p = m_pend; ov = m_ov; ie = m_ien; iq = m_irq; dm = m_dma;
      fc = m_fc;
      cm = m_pend && swap_addresses_enable;
      if (read) m_rd <= m_reg(int'(address));
      if (cm) begin
        f = (m_fidx + 1) % N;
        p = 0;
        fc = m_fc + 32'd1;
      end
      if (write) begin
        case (int'(address))
          0: begin
            if (m_pend && !cm) ov = 1;
            p = 1;
          end
          1: t[(m_fidx + 1) % N] = merge(m_tab[(m_fidx + 1) % N], writedata, byteenable);
          3: if (byteenable[0]) begin
            dm = writedata[2];
            ie = writedata[4];
            if (writedata[3]) ov = 0;
            if (writedata[5]) iq = 0;
          end
          4: if (writedata < 32'(N)) s = int'(writedata);
          5: t[m_sel] = merge(m_tab[m_sel], writedata, byteenable);
          6: fc = 32'd0;
          default: ;
        endcase
      end
      if (cm && m_ien) iq = 1;
      for (int i = 0; i < N; i++) m_tab[i] <= t[i];
      m_fidx <= f; m_sel <= s; m_pend <= p; m_ov <= ov; m_ien <= ie; m_irq <= iq;
      m_dma <= dm; m_fc <= fc; m_sd <= cm;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("readdata", readdata, m_rd);
      cmp("current_start_address", current_start_address, m_tab[m_fidx]);
      cmp("next_start_address", next_start_address, m_tab[(m_fidx + 1) % N]);
      cmp("dma_enabled", 32'(dma_enabled), 32'(m_dma));
      cmp("irq", 32'(irq), 32'(m_irq));
      cmp("swap_done", 32'(swap_done), 32'(m_sd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit sw);
    reset = 1'b0; read = rd; write = wr; address = a; writedata = d; byteenable = be;
    swap_addresses_enable = sw;
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    cyc(1'b0, 1'b1, a, d, be, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cyc(1'b1, 1'b0, a, 32'd0, 4'h0, 1'b0);
    d = readdata;
  endtask

  task automatic strobe();
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b0);
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
    swap_addresses_enable = 0;
    repeat (2) @(negedge clk);
    #1;
    cmp("rst_readdata", readdata, 32'd0);
    cmp("rst_current", current_start_address, 32'd0);
    cmp("rst_dma_enabled", 32'(dma_enabled), 32'd1);
    cmp("rst_swap_done", 32'(swap_done), 32'd0);

    rd(3'd2, v); cmp("resolution", v, 32'h01E00280);
    rd(3'd3, v); cmp("status_reset", v, 32'h00030006);
    rd(3'd0, v); cmp("front_reset", v, 32'h00000000);

    wr(3'd4, 0); wr(3'd5, 32'h1000);
    wr(3'd4, 1); wr(3'd5, 32'h2000);
    wr(3'd4, 2); wr(3'd5, 32'h3000);
    cmp("current_slot0", current_start_address, 32'h1000);
    wr(3'd0, 0); strobe();
    cmp("current_after_swap", current_start_address, 32'h2000);
    cmp("swap_done_pulse", 32'(swap_done), 32'd1);
    idle();
    cmp("swap_done_clear", 32'(swap_done), 32'd0);
    rd(3'd6, v); cmp("frame_count_1", v, 32'd1);

    wr(3'd0, 0); strobe(); wr(3'd0, 0); strobe();
    cmp("current_wrap", current_start_address, 32'h1000);
    rd(3'd6, v); cmp("frame_count_3", v, 32'd3);

    wr(3'd3, 32'h14); wr(3'd0, 0); wr(3'd0, 0);
    rd(3'd3, v); cmp("status_overrun", v, 32'h0003001F);
    strobe();
    cmp("irq_set", 32'(irq), 32'd1);
    wr(3'd3, 32'h38);
    rd(3'd3, v); cmp("status_cleared", v, 32'h00030112);
    cmp("irq_cleared", 32'(irq), 32'd0);
    wr(3'd3, 32'h14);

    wr(3'd0, 0);
    cyc(1'b0, 1'b1, 3'd0, 32'd0, 4'hF, 1'b1);
    rd(3'd3, v); cmp("front_with_commit", v, 32'h00030237);
    strobe();
    cmp("second_advance", current_start_address, 32'h1000);

    wr(3'd1, 32'h0000AB00, 4'b0010);
    cmp("back_byte_write", next_start_address, 32'h0000AB00);
    rd(3'd1, v); cmp("back_read", v, 32'h0000AB00);
    wr(3'd4, 5);
    rd(3'd4, v); cmp("slot_sel_reject", v, 32'd2);

    wr(3'd0, 0);
    cyc(1'b0, 1'b1, 3'd6, 32'd0, 4'hF, 1'b1);
    rd(3'd6, v); cmp("fc_clear_vs_commit", v, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      read = $urandom_range(0, 1);
      write = ($urandom_range(0, 2) == 0);
      address = 3'($urandom_range(0, 7));
      byteenable = 4'($urandom);
      if (address == 3'd4) writedata = 32'($urandom_range(0, 6));
      else if (address == 3'd3) writedata = 32'($urandom_range(0, 255));
      else writedata = $urandom;
      swap_addresses_enable = ($urandom_range(0, 3) == 0);
      @(negedge clk); #1;
    end
    idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
